pipe_cla_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor for the EXU datapath.
- Each pipeline stage resolves one BLOCK-bit slice of the operands with a carry-lookahead slice adder (4-bit CLA groups plus a CLU).
- The carry ripples between stages through registers, so wide adds close timing at high clock rates.
- Valid/ready handshake in and out; full throughput of one operation per cycle when not stalled.

---
 rtl/pipe_cla_adder.sv | 153 +++++++++++++++
 tb/tb_pipe_cla_adder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit CLA slice per stage,
// with the carry handed between stages through registers.
module pipe_cla_adder #(
    parameter int WIDTH = 64,
    parameter int BLOCK = 16,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NSTAGE = WIDTH / BLOCK;
    localparam int NGRP   = BLOCK / 4;

    // Returns {carry_out, sum}. Group carries and bit carries are both written as
    // flat generate/propagate products so nothing ripples across CLA4 groups.
    function automatic logic [BLOCK:0] cla_slice(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             cin
    );
        logic [BLOCK-1:0] g, p, s;
        logic [NGRP-1:0]  gg, gp;
        logic [NGRP:0]    gc;
        logic             c, pp;
        g  = a & b;
        p  = a ^ b;
        s  = '0;
        gg = '0;
        gp = '0;
        gc = '0;
        for (int j = 0; j < NGRP; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                gg[j] = g[4*j+i] | (p[4*j+i] & gg[j]);
                gp[j] = gp[j] & p[4*j+i];
            end
        end
        gc[0] = cin;
        for (int j = 0; j < NGRP; j++) begin
            c  = gg[j];
            pp = gp[j];
            for (int i = j - 1; i >= 0; i--) begin
                c  = c | (pp & gg[i]);
                pp = pp & gp[i];
            end
            gc[j+1] = c | (pp & cin);
        end
        for (int j = 0; j < NGRP; j++) begin
            for (int i = 0; i < 4; i++) begin
                c  = 1'b0;
                pp = 1'b1;
                for (int m = i - 1; m >= 0; m--) begin
                    c  = c | (pp & g[4*j+m]);
                    pp = pp & p[4*j+m];
                end
                c = c | (pp & gc[j]);
                s[4*j+i] = p[4*j+i] ^ c;
            end
        end
        return {gc[NGRP], s};
    endfunction

    // Rank 0 is the conditioned operand register; rank k holds slices 0..k-1.
    logic [NSTAGE:0]  vld_q, vld_d;
    logic [NSTAGE:0]  c_q, c_d;
    logic [WIDTH-1:0] x_q   [NSTAGE+1];
    logic [WIDTH-1:0] x_d   [NSTAGE+1];
    logic [WIDTH-1:0] y_q   [NSTAGE+1];
    logic [WIDTH-1:0] y_d   [NSTAGE+1];
    logic [WIDTH-1:0] sum_q [NSTAGE+1];
    logic [WIDTH-1:0] sum_d [NSTAGE+1];
    logic [TAG_W-1:0] tag_q [NSTAGE+1];
    logic [TAG_W-1:0] tag_d [NSTAGE+1];
    logic [BLOCK:0]   slice_res [NSTAGE];
    logic             adv;

    assign adv      = !vld_q[NSTAGE] || out_ready;
    assign in_ready = adv;

    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            slice_res[k] = cla_slice(x_q[k][k*BLOCK +: BLOCK], y_q[k][k*BLOCK +: BLOCK], c_q[k]);
        end
    end

    always_comb begin
        vld_d = vld_q;
        c_d   = c_q;
        x_d   = x_q;
        y_d   = y_q;
        sum_d = sum_q;
        tag_d = tag_q;
        if (adv) begin
            vld_d[0] = in_valid;
            x_d[0]   = in_x;
            y_d[0]   = in_sub ? ~in_y : in_y;
            c_d[0]   = in_sub;
            tag_d[0] = in_tag;
            for (int k = 1; k <= NSTAGE; k++) begin
                vld_d[k] = vld_q[k-1];
                x_d[k]   = x_q[k-1];
                y_d[k]   = y_q[k-1];
                tag_d[k] = tag_q[k-1];
                sum_d[k] = sum_q[k-1];
                sum_d[k][(k-1)*BLOCK +: BLOCK] = slice_res[k-1][BLOCK-1:0];
                c_d[k]   = slice_res[k-1][BLOCK];
            end
        end
        sum_d[0] = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clock) begin
        c_q   <= c_d;
        x_q   <= x_d;
        y_q   <= y_d;
        sum_q <= sum_d;
        tag_q <= tag_d;
    end

    // Data ranks are not reset, so every output is masked by the final valid.
    assign out_valid = vld_q[NSTAGE];
    assign out_sum   = out_valid ? sum_q[NSTAGE] : '0;
    assign out_tag   = out_valid ? tag_q[NSTAGE] : '0;
    assign out_cout  = out_valid & c_q[NSTAGE];
    assign out_zero  = out_valid & ~|sum_q[NSTAGE];
    assign out_ovf   = out_valid
                     & (x_q[NSTAGE][WIDTH-1] == y_q[NSTAGE][WIDTH-1])
                     & (sum_q[NSTAGE][WIDTH-1] != x_q[NSTAGE][WIDTH-1]);

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Bench for pipe_cla_adder: directed vectors, backpressure and reset sequences,
// plus random traffic scored against an arithmetic reference model.
module tb_pipe_cla_adder;

    localparam int W  = 64;
    localparam int B  = 16;
    localparam int TW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, in_sub;
    logic [W-1:0]  in_x, in_y;
    logic [TW-1:0] in_tag;
    logic          out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [W-1:0]  out_sum;
    logic [TW-1:0] out_tag;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pipe_cla_adder #(.WIDTH(W), .BLOCK(B), .TAG_W(TW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_sub    (in_sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    typedef struct {
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic          zero;
        logic [TW-1:0] tag;
    } res_t;

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic          sub;
        logic [TW-1:0] tag;
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic          zero;
    } vec_t;

    res_t exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Plain integer arithmetic: wrapped result, unsigned carry/no-borrow, and
    // overflow as "true signed result does not fit in W bits".
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic sub, input logic [TW-1:0] tag);
        res_t r;
        logic signed [W+1:0] sx, sy, sr;
        sx = $signed({x[W-1], x[W-1], x});
        sy = $signed({y[W-1], y[W-1], y});
        if (sub) begin
            r.sum  = x - y;
            r.cout = (x >= y);
            sr     = sx - sy;
        end else begin
            {r.cout, r.sum} = {1'b0, x} + {1'b0, y};
            sr     = sx + sy;
        end
        r.ovf  = (sr[W+1:W-1] != {3{sr[W-1]}});
        r.zero = (r.sum == '0);
        r.tag  = tag;
        return r;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            4:       return W'($urandom_range(0, 65535));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Scoreboard: handshakes are sampled mid-cycle, i.e. what the next rising edge sees.
    res_t                mon_r;
    logic                prev_stall = 1'b0;
    logic [W+TW+3:0]     prev_out;

    always @(negedge clock) begin
        if (reset !== 1'b1) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag}, prev_out);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected actual=%0h required=no_result", out_sum);
                end else begin
                    mon_r = exp_q.pop_front();
                    check("mon_sum", out_sum, mon_r.sum);
                    check("mon_flags", {out_cout, out_ovf, out_zero}, {mon_r.cout, mon_r.ovf, mon_r.zero});
                    check("mon_tag", out_tag, mon_r.tag);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag};
            if (in_valid && in_ready)
                exp_q.push_back(model(in_x, in_y, in_sub, in_tag));
        end
    end

    // Issues one op into an idle pipe and checks latency and all result fields.
    task automatic run_vec(input vec_t v, input string nm);
        int cyc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = v.x;
        in_y      = v.y;
        in_sub    = v.sub;
        in_tag    = v.tag;
        @(posedge clock); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 12) begin
            @(posedge clock); #1;
            cyc++;
        end
        check({nm, "_latency"}, cyc, 4);
        check({nm, "_sum"}, out_sum, v.sum);
        check({nm, "_cout"}, out_cout, v.cout);
        check({nm, "_ovf"}, out_ovf, v.ovf);
        check({nm, "_zero"}, out_zero, v.zero);
        check({nm, "_tag"}, out_tag, v.tag);
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    vec_t vecs[7];
    vec_t v_post;
    int   sent, got, stall, n;

    initial begin
        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 4'd3,
                    64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 4'd1,
                    64'h0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{64'h5, 64'h7, 1'b1, 4'd2,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 4'd4,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 4'd5,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{64'h5, 64'h5, 1'b1, 4'd6,
                    64'h0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 4'd7,
                    64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0};
        v_post  = '{64'd1000, 64'd234, 1'b0, 4'd9,
                    64'd1234, 1'b0, 1'b0, 1'b0};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_sub    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_outputs", {out_sum, out_cout, out_ovf, out_zero, out_tag}, 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        idle(3);

        // Six back-to-back ops, with a three-cycle consumer stall on the first result.
        sent  = 0;
        got   = 0;
        stall = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (out_valid && stall < 3) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (!out_ready) check("bp_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                check("bp_sum", out_sum, 100 + got);
                check("bp_tag", out_tag, got);
                got++;
            end
            if (sent < 6) begin
                in_valid = 1'b1;
                in_x     = W'(sent);
                in_y     = 64'd100;
                in_sub   = 1'b0;
                in_tag   = TW'(sent);
                if (in_ready) sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clock); #1;
        end
        check("bp_count", got, 6);
        check("bp_stall_cycles", stall, 3);
        idle(3);

        // Random traffic with random producer/consumer pacing.
        for (int cyc = 0; cyc < 500; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_x      = pick_operand();
            in_y      = pick_operand();
            in_sub    = 1'($urandom_range(0, 1));
            in_tag    = TW'($urandom_range(0, 15));
            @(posedge clock); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clock); #1;
            n++;
        end
        check("rand_drained", exp_q.size(), 0);
        idle(3);

        // Reset with three ops in flight: none of them may surface.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_x     = W'(i + 10);
            in_y     = W'(i);
            in_sub   = 1'b0;
            in_tag   = TW'(i);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("rst_mid_no_valid", out_valid, 0);
            @(posedge clock); #1;
        end
        run_vec(v_post, "post_rst");
        idle(4);
        check("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
